count_stepper: RTL and testbench
================================

// Module: count_stepper
// PURPOSE
//  Command-side driver for the up/down counter: accepts a target count over a
//  valid/ready handshake and emits single-cycle increment/decrement pulses
//  that step the counter to the target by the shortest modulo-2^WIDTH path.
//  Keeps a shadow copy of the counter value (position). Sits between control
//  logic (or a testbench sequencer) and the counter's increment/decrement pins.
// PARAMETERS
//  WIDTH     4  counter width in bits; all position arithmetic is mod 2^WIDTH
//  STEP_GAP  1  idle cycles between consecutive pulses (0 = back-to-back)
// PORTS
//  clk           in   1      clock; all state changes on posedge
//  reset         in   1      synchronous, active-high; same reset as the counter
//  target_valid  in   1      target presented
//  target        in   WIDTH  requested count value
//  target_ready  out  1      high only in IDLE; accept = valid & ready at posedge
//  increment     out  1      one-cycle step-up pulse to counter
//  decrement     out  1      one-cycle step-down pulse to counter
//  busy          out  1      high from cycle after accept through DONE cycle
//  done          out  1      one-cycle pulse: position == latched target
//  position      out  WIDTH  shadow count; equals counter value every cycle
// BEHAVIOUR
//  - Reset: state IDLE; target_ready=1; increment=decrement=busy=done=0;
//    position=0; gap counter=0. Reset wins over all other inputs, including
//    mid-move: pulses stop next cycle, position returns to 0 with the counter.
//  - All outputs registered; increment and decrement never high together.
//  - FSM IDLE -> STEP -> (GAP -> STEP)* -> DONE -> IDLE.
//  - IDLE: on accept latch target; up=(target-position) mod 2^W,
//    dn=(position-target) mod 2^W; dir=UP if up<=dn else DOWN (tie -> UP).
//    If target==position go DONE directly (zero pulses); else go STEP.
//  - STEP (one cycle): drive increment (UP) or decrement (DOWN) high; at the
//    closing edge position <= position +/-1 mod 2^W (wraps 15<->0 at W=4).
//    Next: DONE if new position==target; else GAP if STEP_GAP>0; else STEP.
//  - GAP: pulses low for exactly STEP_GAP cycles, then STEP. dir fixed for
//    the whole move; never re-evaluated.
//  - DONE: done=1, busy=1, target_ready=0 for one cycle, then IDLE.
//  - target_valid/target while not IDLE are ignored (not queued).
//  - Timing, accept at edge E, distance d>0, G=STEP_GAP: pulse k high in
//    cycle 1+(k-1)(1+G) after E; done in cycle 2+(d-1)(1+G); target_ready
//    high the following cycle. d=0: done in cycle 1.
//  - Max pulses per move = 2^(WIDTH-1) (tie case).
// TESTING (bench instantiates counter + count_stepper, STEP_GAP=1 unless noted)
//  1 reset, target=3 -> increment in cycles 1,3,5; no decrement; done cycle 6;
//    position=3, counter count=3.
//  2 from 3, target=1 -> 2 decrement pulses; position/count 2 then 1; done.
//  3 wrap: from 1, target=14 (up=13, dn=3) -> 3 decrements; position 0,15,14.
//  4 tie: from 14, target=6 (up=dn=8) -> 8 increments, 15,0,1..6; never dec.
//  5 target==position (6) -> zero pulses; done in cycle 1; ready cycle 2.
//    Also STEP_GAP=0, 0->2: increment high cycles 1-2 contiguous, done cycle 3.
//  6 reset asserted mid-move (after 2 pulses of 0->5) -> next cycle pulses=0,
//    position=0, ready=1; target_valid while busy ignored; position==count
//    checked every cycle of all tests.

Source files
------------

// File: rtl/count_stepper.sv
// Command-side driver for an up/down counter: accepts a target count and steps
// the counter there by the shortest modulo-2^WIDTH path using one-cycle pulses.
module count_stepper #(
  parameter int WIDTH    = 4,
  parameter int STEP_GAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             target_valid,
  input  logic [WIDTH-1:0] target,
  output logic             target_ready,
  output logic             increment,
  output logic             decrement,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] position
);

  localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dir_up_q, dir_up_d;
  logic             ready_q, ready_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] up_dist, dn_dist;

  assign up_dist = target - position_q;
  assign dn_dist = position_q - target;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    position_d = position_q;
    gap_d      = gap_q;
    dir_up_d   = dir_up_q;

    case (state_q)
      S_IDLE: begin
        if (target_valid) begin
          target_d = target;
          dir_up_d = (up_dist <= dn_dist);
          state_d  = (target == position_q) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        position_d = dir_up_q ? position_q + WIDTH'(1) : position_q - WIDTH'(1);
        if (position_d == target_q) begin
          state_d = S_DONE;
        end else if (STEP_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_STEP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_STEP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies, so they
    // line up with the state they describe without any combinational path out.
    ready_d = (state_d == S_IDLE);
    inc_d   = (state_d == S_STEP) &&  dir_up_d;
    dec_d   = (state_d == S_STEP) && !dir_up_d;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      position_q <= '0;
      gap_q      <= '0;
      dir_up_q   <= 1'b1;
      ready_q    <= 1'b1;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      position_q <= position_d;
      gap_q      <= gap_d;
      dir_up_q   <= dir_up_d;
      ready_q    <= ready_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign target_ready = ready_q;
  assign increment    = inc_q;
  assign decrement    = dec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign position     = position_q;

endmodule

// File: tb/tb_count_stepper.sv
// Directed bench for count_stepper: a STEP_GAP=1 instance for the move table and
// reset-mid-move case, a STEP_GAP=0 instance for back-to-back pulses.
module tb_count_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       target_valid, target_valid1;
  logic [3:0] target, target1;
  logic       target_ready, increment, decrement, busy, done;
  logic       target_ready1, increment1, decrement1, busy1, done1;
  logic [3:0] position, position1;

  logic [3:0] cnt, cnt1;
  logic [3:0] exp_pos;
  bit         armed = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  count_stepper #(.WIDTH(4), .STEP_GAP(1)) dut (
    .clk(clk), .reset(reset), .target_valid(target_valid), .target(target),
    .target_ready(target_ready), .increment(increment), .decrement(decrement),
    .busy(busy), .done(done), .position(position)
  );

  count_stepper #(.WIDTH(4), .STEP_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .target_valid(target_valid1), .target(target1),
    .target_ready(target_ready1), .increment(increment1), .decrement(decrement1),
    .busy(busy1), .done(done1), .position(position1)
  );

  // Counters driven by the stepper pulses.
  always @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      cnt1 <= '0;
    end else begin
      if (increment)       cnt <= cnt + 4'd1;
      else if (decrement)  cnt <= cnt - 4'd1;
      if (increment1)      cnt1 <= cnt1 + 4'd1;
      else if (decrement1) cnt1 <= cnt1 - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("pos_eq_cnt", position, cnt);
      check("pos_eq_cnt_g0", position1, cnt1);
      check("no_inc_and_dec", increment & decrement, 0);
      check("no_inc_and_dec_g0", increment1 & decrement1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One move on the STEP_GAP=1 instance; d and direction are hand-computed.
  task automatic do_move(input string tag, input logic [3:0] tgt, input bit up, input int d);
    int  last;
    bit  pulse;
    check({tag, "_ready_before"}, target_ready, 1);
    target_valid = 1'b1;
    target       = tgt;
    tick();
    // Garbage request held during the move must be ignored.
    target       = ~tgt;
    last = (d == 0) ? 1 : 2 + (d - 1) * 2;
    for (int c = 1; c <= last; c++) begin
      if (c == last) target_valid = 1'b0;
      pulse = (d > 0) && (c < last) && ((c - 1) % 2 == 0);
      check({tag, "_inc"},   increment,    pulse && up);
      check({tag, "_dec"},   decrement,    pulse && !up);
      check({tag, "_done"},  done,         c == last);
      check({tag, "_busy"},  busy,         1);
      check({tag, "_ready"}, target_ready, 0);
      check({tag, "_pos"},   position,     exp_pos);
      if (pulse) exp_pos = up ? exp_pos + 4'd1 : exp_pos - 4'd1;
      tick();
    end
    target_valid = 1'b0;
    check({tag, "_ready_after"}, target_ready, 1);
    check({tag, "_busy_after"},  busy,         0);
    check({tag, "_done_after"},  done,         0);
    check({tag, "_pos_final"},   position,     tgt);
  endtask

  initial begin
    reset         = 1'b1;
    target_valid  = 1'b0;
    target        = '0;
    target_valid1 = 1'b0;
    target1       = '0;
    exp_pos       = '0;
    tick();
    tick();
    reset = 1'b0;
    armed = 1'b1;
    check("rst_ready", target_ready, 1);
    check("rst_inc",   increment,    0);
    check("rst_dec",   decrement,    0);
    check("rst_busy",  busy,         0);
    check("rst_done",  done,         0);
    check("rst_pos",   position,     0);
    check("rst_ready_g0", target_ready1, 1);
    tick();

    do_move("up3",     4'd3,  1'b1, 3);
    do_move("dn2",     4'd1,  1'b0, 2);
    do_move("wrap_dn", 4'd14, 1'b0, 3);
    do_move("tie_up",  4'd6,  1'b1, 8);
    do_move("same",    4'd6,  1'b1, 0);

    // Back-to-back pulses with STEP_GAP=0: 0 -> 2.
    target_valid1 = 1'b1;
    target1       = 4'd2;
    tick();
    target_valid1 = 1'b0;
    check("g0_c1_inc",  increment1, 1);
    check("g0_c1_pos",  position1,  0);
    check("g0_c1_done", done1,      0);
    tick();
    check("g0_c2_inc",  increment1, 1);
    check("g0_c2_pos",  position1,  1);
    check("g0_c2_done", done1,      0);
    tick();
    check("g0_c3_inc",  increment1, 0);
    check("g0_c3_done", done1,      1);
    check("g0_c3_pos",  position1,  2);
    tick();
    check("g0_c4_ready", target_ready1, 1);
    check("g0_c4_done",  done1,         0);

    // Reset mid-move: 0 -> 5 interrupted after two pulses.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_pos = '0;
    tick();
    target_valid = 1'b1;
    target       = 4'd5;
    tick();
    target_valid = 1'b0;
    check("mid_c1_inc", increment, 1);
    tick();
    tick();
    check("mid_c3_inc", increment, 1);
    tick();
    check("mid_c4_pos", position, 2);
    check("mid_c4_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_inc",   increment,    0);
    check("mid_rst_dec",   decrement,    0);
    check("mid_rst_pos",   position,     0);
    check("mid_rst_ready", target_ready, 1);
    check("mid_rst_busy",  busy,         0);
    check("mid_rst_done",  done,         0);
    exp_pos = '0;
    do_move("after_rst", 4'd1, 1'b1, 1);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
